uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among N_REQ requesters
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic               err,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_d, done_d;
    logic             err_d, tx_start_d;
    logic [7:0]       tx_data_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [IW-1:0]    last_q, last_d, owner_q, owner_d;
    logic [IW-1:0]    pick_idx;
    logic             pick_found;
    int               cand;

    // Round-robin pick: scan from last_owner+1 upward; descending loop lets the nearest requester win
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = (int'(last_q) + off) % N_REQ;
            if (req[IW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(cand);
            end
        end
    end

    // Next-state and next-output logic; every output is registered from these values
    always_comb begin
        state_d    = state_q;
        grant_d    = grant;
        done_d     = '0;
        err_d      = 1'b0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data;
        cnt_d      = cnt_q;
        last_d     = last_q;
        owner_d    = owner_q;
        cnt_inc    = cnt_q + CW'(1);
        case (state_q)
            IDLE: begin
                grant_d = '0;
                // A busy transmitter here is leftover activity we did not start; wait it out
                if (!tx_busy && pick_found) begin
                    grant_d   = N_REQ'(1) << pick_idx;
                    owner_d   = pick_idx;
                    tx_data_d = req_data[{pick_idx, 3'b000} +: 8];
                    state_d   = START;
                end
            end
            START: begin
                tx_start_d = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(BUSY_TIMEOUT)) begin
                        // Aborted owner still moves to lowest priority
                        done_d  = grant;
                        err_d   = 1'b1;
                        last_d  = owner_q;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    done_d  = grant;
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 with highest priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant    <= '0;
            done     <= '0;
            err      <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            cnt_q    <= '0;
            last_q   <= IW'(N_REQ - 1);
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant    <= grant_d;
            done     <= done_d;
            err      <= err_d;
            tx_start <= tx_start_d;
            tx_data  <= tx_data_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 6;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [31:0]  req_data;
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic         err;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         tx_busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .done     (done),
        .err      (err),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_grant(input int idx, input logic [7:0] d);
        step();
        chk("grant", 32'(grant), 32'(1 << idx));
        chk("start_low_at_grant", 32'(tx_start), 32'(0));
        chk("tx_data_latched", 32'(tx_data), 32'(d));
    endtask

    task automatic finish_xfer(input int idx, input logic [7:0] d, input int busy_len);
        step();
        chk("tx_start_pulse", 32'(tx_start), 32'(1));
        chk("grant_in_start", 32'(grant), 32'(1 << idx));
        tx_busy = 1'b1;
        step();
        chk("tx_start_single", 32'(tx_start), 32'(0));
        for (int i = 0; i < busy_len; i++) begin
            step();
            chk("no_done_while_busy", 32'(done), 32'(0));
            chk("no_restart", 32'(tx_start), 32'(0));
        end
        tx_busy = 1'b0;
        step();
        chk("done_pulse", 32'(done), 32'(1 << idx));
        chk("err_clear", 32'(err), 32'(0));
        chk("grant_at_done", 32'(grant), 32'(1 << idx));
        chk("tx_data_at_done", 32'(tx_data), 32'(d));
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        tx_busy  = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_tx_start", 32'(tx_start), 32'(0));
        chk("rst_tx_data", 32'(tx_data), 32'(0));
        step();
        step();
        rst = 1'b1;

        // single requester 2
        req_data = 32'h00A5_0000;
        req      = 4'b0100;
        expect_grant(2, 8'hA5);
        finish_xfer(2, 8'hA5, 4);
        req = '0;
        step();
        chk("single_idle_grant", 32'(grant), 32'(0));
        chk("single_done_once", 32'(done), 32'(0));

        // fresh reset so contention starts at requester 0
        rst = 1'b0;
        step();
        rst = 1'b1;

        // contention: all four held
        req_data = 32'h4433_2211;
        req      = 4'b1111;
        expect_grant(0, 8'h11);
        finish_xfer(0, 8'h11, 2);
        expect_grant(1, 8'h22);
        finish_xfer(1, 8'h22, 2);
        expect_grant(2, 8'h33);
        finish_xfer(2, 8'h33, 2);
        expect_grant(3, 8'h44);
        finish_xfer(3, 8'h44, 2);
        expect_grant(0, 8'h11);
        finish_xfer(0, 8'h11, 2);
        req = '0;
        step();
        chk("cont_idle_grant", 32'(grant), 32'(0));

        // timeout on requester 1, transmitter never goes busy
        req = 4'b0110;
        expect_grant(1, 8'h22);
        step();
        chk("to_tx_start", 32'(tx_start), 32'(1));
        for (int i = 1; i < TO; i++) begin
            step();
            chk("to_no_done_early", 32'(done), 32'(0));
            chk("to_no_err_early", 32'(err), 32'(0));
        end
        step();
        chk("to_done", 32'(done), 32'(4'b0010));
        chk("to_err", 32'(err), 32'(1));
        chk("to_grant_held", 32'(grant), 32'(4'b0010));

        // aborted requester lost priority: requester 2 next
        expect_grant(2, 8'h33);
        chk("to_done_cleared", 32'(done), 32'(0));
        chk("to_err_cleared", 32'(err), 32'(0));

        // data hazard mid-frame on requester 2
        step();
        chk("hz_tx_start", 32'(tx_start), 32'(1));
        tx_busy = 1'b1;
        step();
        req      = '0;
        req_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hz_tx_data_stable", 32'(tx_data), 32'(8'h33));
        end
        tx_busy = 1'b0;
        step();
        chk("hz_done", 32'(done), 32'(4'b0100));
        chk("hz_tx_data", 32'(tx_data), 32'(8'h33));
        step();
        chk("hz_grant_cleared", 32'(grant), 32'(0));

        // reset mid-frame while requester 1 owns the transmitter
        req_data = 32'h4433_2211;
        req      = 4'b0010;
        expect_grant(1, 8'h22);
        step();
        tx_busy = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("mr_grant", 32'(grant), 32'(0));
        chk("mr_done", 32'(done), 32'(0));
        chk("mr_err", 32'(err), 32'(0));
        chk("mr_tx_start", 32'(tx_start), 32'(0));
        chk("mr_tx_data", 32'(tx_data), 32'(0));
        req     = 4'b1010;
        tx_busy = 1'b0;
        step();
        step();
        chk("mr_no_done", 32'(done), 32'(0));
        rst = 1'b1;
        expect_grant(1, 8'h22);
        req = '0;
        finish_xfer(1, 8'h22, 2);
        step();
        chk("mr_idle_grant", 32'(grant), 32'(0));

        // stale busy in IDLE blocks the grant
        tx_busy = 1'b1;
        req     = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stale_no_grant", 32'(grant), 32'(0));
        end
        tx_busy = 1'b0;
        expect_grant(0, 8'h11);
        req = '0;
        finish_xfer(0, 8'h11, 1);
        step();
        chk("stale_idle_grant", 32'(grant), 32'(0));
        chk("stale_idle_done", 32'(done), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
